ahb_slave_if: RTL
=================

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: Hclk, Hresetn.
REQ-002 Hclk  input  1  rising-edge clock for all state.
REQ-003 Hresetn  input  1  asynchronous active-low reset.
REQ-004 Hwrite  input  1  transfer direction, 1 = write; sampled in the address phase.
REQ-005 Hreadyin  input  1  bus-ready; an address phase is sampled only when this is 1.
REQ-006 Htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 Haddr  input  32  transfer address.
REQ-008 Hwdata  input  32  write data, valid in the data phase.
REQ-009 Hrdata  output  32  read data, registered.
REQ-010 Hreadyout  output  1  0 = wait state inserted.
REQ-011 Hresp  output  2  00 OKAY, 01 ERROR.
REQ-012 bk_req, bk_write  output  1 each  backend request and direction.
REQ-013 bk_addr, bk_wdata  output  32 each  backend address and write data.
REQ-014 bk_sel  output  3  one-hot region select.
REQ-015 bk_ack  input  1  backend completion.
REQ-016 bk_rdata  input  32  backend read data, valid with bk_ack.

Function
REQ-017 Valid transfer: Hreadyin=1, Htrans in {NONSEQ, SEQ}, and Haddr in 0x8000_0000..0x83FF_FFFF; all other combinations are ignored.
REQ-018 Address decode: 0x80xx_xxxx gives bk_sel=001, 0x81xx_xxxx gives 010, 0x82xx_xxxx gives 100; 0x83xx_xxxx is unmapped.
REQ-019 States: IDLE, DATA, ACCESS, ERR1, ERR2; transitions occur on the rising edge of Hclk.
REQ-020 IDLE: Hreadyout=1, Hresp=OKAY.
- On a valid mapped transfer: latch Haddr, Hwrite and sel, then go to DATA.
- On a valid unmapped transfer: go to ERR1.
- Otherwise: stay in IDLE.
REQ-021 DATA: Hreadyout=0; capture Hwdata into bk_wdata (writes only); go to ACCESS with bk_req=1.
REQ-022 ACCESS: Hreadyout=0; bk_req, bk_write, bk_addr, bk_wdata and bk_sel hold stable until bk_ack=1.
REQ-023 ACCESS, on bk_ack=1: go to IDLE with bk_req=0 on the next cycle; for reads, load bk_rdata into Hrdata on that same edge.
REQ-024 ERR1: Hreadyout=0, Hresp=ERROR; go to ERR2.
REQ-025 ERR2: Hreadyout=1, Hresp=ERROR; accept a new valid transfer exactly as IDLE does, otherwise go to IDLE.
REQ-026 Minimum latency, address-phase edge to the Hreadyout=1 data-phase end: 3 cycles (2 wait states) when bk_ack arrives in the first ACCESS cycle.
REQ-027 Hrdata SHALL hold its last loaded value; a write or an error SHALL NOT change it.
REQ-028 bk_ack outside ACCESS SHALL be ignored.
- A valid transfer presented while Hreadyout=0 is not sampled, because the master holds Hreadyin low.
REQ-029 No combinational path from any input to any output; all outputs SHALL be decoded from the state register or taken from registers.

Reset
REQ-030 While Hresetn=0: state=IDLE; Hreadyout=1; Hresp=00; Hrdata=0; bk_req=0; bk_write=0; bk_addr=0; bk_wdata=0; bk_sel=000.
REQ-031 Reset asserted mid-ACCESS SHALL drop bk_req immediately (asynchronously), and the pending transfer SHALL be discarded.
REQ-032 After Hresetn deasserts, the first valid transfer is sampled on the first rising edge of Hclk.

Structure
REQ-033 Shared package ahb_pkg SHALL hold: HTRANS codes, HRESP codes, the state encoding, and region base/limit constants.
REQ-034 Address decode SHALL be one combinational sub-module, ahb_addr_decode (inputs Haddr; outputs sel[2:0], mapped, in_range).

Verification
REQ-035 Single write to 0x8000_0001 with Hwdata=0xA3 and bk_ack on the first ACCESS cycle -> bk_req high exactly one cycle; bk_sel=001; bk_wdata=0xA3; Hreadyout low for 2 cycles; Hresp=OKAY.
REQ-036 Single read from 0x8100_00A2, bk_ack after 3 ACCESS cycles with bk_rdata=0x1234_5678 -> bk_sel=010; Hreadyout low for 4 cycles; Hrdata=0x1234_5678 when Hreadyout returns to 1.
REQ-037 NONSEQ to 0x8300_0000 -> ERR1 (Hreadyout=0, Hresp=01), then ERR2 (Hreadyout=1, Hresp=01), then IDLE; bk_req stays 0 throughout.
REQ-038 Htrans=IDLE or BUSY to 0x8000_0000, and NONSEQ with Hreadyin=0 -> no state change; bk_req=0.
REQ-039 Back-to-back: NONSEQ to 0x8300_0000, then a write to 0x8200_0004 presented during ERR2 -> the write is accepted; bk_sel=100.
REQ-040 Hresetn pulsed low during ACCESS -> bk_req=0 with no clock edge needed; all outputs at reset values; next transfer completes normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared definitions for the AHB slave interface: bus codes, FSM states and
// the address map of the three backend regions.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Whole decoded window; the top 16 MB slice of it has no backend.
  localparam logic [31:0] AHB_BASE  = 32'h8000_0000;
  localparam logic [31:0] AHB_LIMIT = 32'h83FF_FFFF;

  localparam int unsigned NUM_REGIONS = 3;

  localparam logic [NUM_REGIONS-1:0][31:0] REGION_BASE = {
    32'h8200_0000, 32'h8100_0000, 32'h8000_0000
  };
  localparam logic [NUM_REGIONS-1:0][31:0] REGION_LIMIT = {
    32'h82FF_FFFF, 32'h81FF_FFFF, 32'h80FF_FFFF
  };

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational region decode: one-hot backend select plus window checks.
module ahb_addr_decode
  import ahb_pkg::*;
(
  input  logic [31:0] Haddr,
  output logic [2:0]  sel,
  output logic        mapped,
  output logic        in_range
);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      sel[i] = (Haddr >= REGION_BASE[i]) && (Haddr <= REGION_LIMIT[i]);
    end
    in_range = (Haddr >= AHB_BASE) && (Haddr <= AHB_LIMIT);
    mapped   = |sel;
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front end bridging single transfers to a simple req/ack backend;
// unmapped addresses inside the window get a two-cycle ERROR response.
module ahb_slave_if
  import ahb_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic [31:0] Hrdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic        bk_req,
  output logic        bk_write,
  output logic [31:0] bk_addr,
  output logic [31:0] bk_wdata,
  output logic [2:0]  bk_sel,
  input  logic        bk_ack,
  input  logic [31:0] bk_rdata
);

  state_e      r_state;
  state_e      w_next;

  logic [2:0]  w_sel;
  logic        w_mapped;
  logic        w_in_range;
  logic        w_valid;
  logic        w_take;

  logic [31:0] r_hrdata;
  logic        r_bk_write;
  logic [31:0] r_bk_addr;
  logic [31:0] r_bk_wdata;
  logic [2:0]  r_bk_sel;

  ahb_addr_decode u_decode (
    .Haddr    (Haddr),
    .sel      (w_sel),
    .mapped   (w_mapped),
    .in_range (w_in_range)
  );

  assign w_valid = Hreadyin && w_in_range &&
                   ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));

  // ERR2 drives Hreadyout=1, so it samples address phases exactly like IDLE.
  assign w_take = w_valid && w_mapped &&
                  ((r_state == ST_IDLE) || (r_state == ST_ERR2));

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    Hreadyout = 1'b1;
    Hresp     = HRESP_OKAY;
    bk_req    = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (r_state == ST_ERR2) Hresp = HRESP_ERROR;
        if (w_valid) w_next = w_mapped ? ST_DATA : ST_ERR1;
        else         w_next = ST_IDLE;
      end
      ST_DATA: begin
        Hreadyout = 1'b0;
        w_next    = ST_ACCESS;
      end
      ST_ACCESS: begin
        Hreadyout = 1'b0;
        bk_req    = 1'b1;
        if (bk_ack) w_next = ST_IDLE;
      end
      ST_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = HRESP_ERROR;
        w_next    = ST_ERR2;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_hrdata   <= '0;
      r_bk_write <= 1'b0;
      r_bk_addr  <= '0;
      r_bk_wdata <= '0;
      r_bk_sel   <= '0;
    end else begin
      if (w_take) begin
        r_bk_addr  <= Haddr;
        r_bk_write <= Hwrite;
        r_bk_sel   <= w_sel;
      end
      if ((r_state == ST_DATA) && r_bk_write) begin
        r_bk_wdata <= Hwdata;
      end
      if ((r_state == ST_ACCESS) && bk_ack && !r_bk_write) begin
        r_hrdata <= bk_rdata;
      end
    end
  end

  assign Hrdata   = r_hrdata;
  assign bk_write = r_bk_write;
  assign bk_addr  = r_bk_addr;
  assign bk_wdata = r_bk_wdata;
  assign bk_sel   = r_bk_sel;

endmodule
